// File: rtl/pc_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen_if
//  Purpose  : Bundles the request inputs and status outputs of pc_gen.
//             master : pipeline/control side (drives requests, sees PC).
//             slave  : pc_gen side.
//  Signals  : stall, flush/flush_target, branch_taken/branch_target,
//             Jump/jal_target, JumpR/jalr_target, call, ret   (to pc_gen)
//             pc, redirect, misalign_err/misalign_addr,
//             ras_top/ras_valid                                (from pc_gen)
//  Revision : 1.0 - initial release
// ============================================================================
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] flush_target;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            Jump;
  logic [XLEN-1:0] jal_target;
  logic            JumpR;
  logic [XLEN-1:0] jalr_target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc;
  logic            redirect;
  logic            misalign_err;
  logic [XLEN-1:0] misalign_addr;
  logic [XLEN-1:0] ras_top;
  logic            ras_valid;

  modport master (
    output stall, flush, flush_target, branch_taken, branch_target,
           Jump, jal_target, JumpR, jalr_target, call, ret,
    input  pc, redirect, misalign_err, misalign_addr, ras_top, ras_valid
  );

  modport slave (
    input  stall, flush, flush_target, branch_taken, branch_target,
           Jump, jal_target, JumpR, jalr_target, call, ret,
    output pc, redirect, misalign_err, misalign_addr, ras_top, ras_valid
  );
endinterface
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Fetch program-counter generator with flush/jump/branch
//             redirection, misaligned-target trapping and an optional
//             circular return-address stack.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - pc_gen_if.slave (requests in, pc/status out)
//  Config   : define PC_GEN_RAS_EN to build the return-address stack;
//             otherwise ras_top/ras_valid are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              RAS_DEPTH    = 4
) (
  input wire logic   clk,
  input wire logic   rst_n,
  pc_gen_if.slave    bus
);

  localparam logic [XLEN-1:0] c_four = XLEN'(4);

  logic [XLEN-1:0] r_pc;
  logic            r_redirect;
  logic            r_misalign_err;
  logic [XLEN-1:0] r_misalign_addr;

  logic            w_adv;
  logic            w_take;
  logic [XLEN-1:0] w_tgt;
  logic            w_misal;
  logic [XLEN-1:0] w_pc_inc;

  assign w_adv    = ~bus.stall & ~bus.flush;
  assign w_pc_inc = r_pc + c_four;   // wraps silently modulo 2^XLEN

  // Control-transfer target selection: JumpR > Jump > branch.
  always_comb begin
    w_take = 1'b0;
    w_tgt  = '0;
    if (bus.JumpR) begin
      w_take = 1'b1;
      w_tgt  = bus.jalr_target;
    end else if (bus.Jump) begin
      w_take = 1'b1;
      w_tgt  = bus.jal_target;
    end else if (bus.branch_taken) begin
      w_take = 1'b1;
      w_tgt  = bus.branch_target;
    end
  end

  assign w_misal = w_take & (w_tgt[1:0] != 2'b00);

  // PC, redirect and misalignment reporting. flush wins over stall and is
  // never alignment-checked; stall freezes the PC but drops the pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc            <= RESET_VECTOR;
      r_redirect      <= 1'b0;
      r_misalign_err  <= 1'b0;
      r_misalign_addr <= '0;
    end else if (bus.flush) begin
      r_pc           <= bus.flush_target;
      r_redirect     <= 1'b1;
      r_misalign_err <= 1'b0;
    end else if (bus.stall) begin
      r_redirect     <= 1'b0;
      r_misalign_err <= 1'b0;
    end else if (w_misal) begin
      r_pc            <= TRAP_VECTOR;
      r_redirect      <= 1'b1;
      r_misalign_err  <= 1'b1;
      r_misalign_addr <= w_tgt;
    end else if (w_take) begin
      r_pc           <= w_tgt;
      r_redirect     <= 1'b1;
      r_misalign_err <= 1'b0;
    end else begin
      r_pc           <= w_pc_inc;
      r_redirect     <= 1'b0;
      r_misalign_err <= 1'b0;
    end
  end

  assign bus.pc            = r_pc;
  assign bus.redirect      = r_redirect;
  assign bus.misalign_err  = r_misalign_err;
  assign bus.misalign_addr = r_misalign_addr;

`ifdef PC_GEN_RAS_EN
  localparam int                c_ptr_w = $clog2(RAS_DEPTH);
  localparam int                c_cnt_w = $clog2(RAS_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(RAS_DEPTH);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_pone = c_ptr_w'(1);

  logic [XLEN-1:0]    r_ras [RAS_DEPTH];
  logic [c_ptr_w-1:0] r_ptr;   // index of the current top entry
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_ptr_w-1:0] w_ptr_up;
  logic               w_link_ok;
  logic               w_push;
  logic               w_pop;

  assign w_ptr_up  = r_ptr + c_pone;
  assign w_link_ok = w_adv & w_take & ~w_misal;
  assign w_push    = w_link_ok & (bus.Jump | bus.JumpR) & bus.call;
  assign w_pop     = w_link_ok & bus.JumpR & bus.ret;

  // Pushing when full lands on ptr+1, which is the oldest slot, so the
  // circular overwrite falls out of the pointer arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else if (w_push && w_pop) begin
      r_ras[r_ptr] <= w_pc_inc;
    end else if (w_push) begin
      r_ras[w_ptr_up] <= w_pc_inc;
      r_ptr           <= w_ptr_up;
      if (r_cnt != c_full) begin
        r_cnt <= r_cnt + c_one;
      end
    end else if (w_pop && (r_cnt != '0)) begin
      r_ptr <= r_ptr - c_pone;
      r_cnt <= r_cnt - c_one;
    end
  end

  assign bus.ras_valid = (r_cnt != '0);
  assign bus.ras_top   = (r_cnt != '0) ? r_ras[r_ptr] : '0;
`else
  assign bus.ras_valid = 1'b0;
  assign bus.ras_top   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_gen
//  Purpose  : Self-checking bench for pc_gen: directed scenarios plus a
//             randomized run compared against a behavioural model. Honours
//             PC_GEN_RAS_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_gen;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] TV    = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc;
  logic        m_red;
  logic        m_mis;
  logic [31:0] m_maddr;
  logic [31:0] m_ras[$];   // back = top of stack

  task automatic model_reset();
    m_pc = RV; m_red = 1'b0; m_mis = 1'b0; m_maddr = '0;
    m_ras.delete();
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    logic        taken;
    logic [31:0] link;
    link  = m_pc + 32'd4;
    taken = 1'b1;
    if (bus.JumpR)             tgt = bus.jalr_target;
    else if (bus.Jump)         tgt = bus.jal_target;
    else if (bus.branch_taken) tgt = bus.branch_target;
    else begin taken = 1'b0; tgt = '0; end

    if (bus.flush) begin
      m_pc = bus.flush_target; m_red = 1'b1; m_mis = 1'b0;
    end else if (bus.stall) begin
      m_red = 1'b0; m_mis = 1'b0;
    end else if (!taken) begin
      m_pc = link; m_red = 1'b0; m_mis = 1'b0;
    end else if (tgt % 4 != 0) begin
      m_pc = TV; m_red = 1'b1; m_mis = 1'b1; m_maddr = tgt;
    end else begin
`ifdef PC_GEN_RAS_EN
      begin
        bit push, pop;
        push = (bus.Jump || bus.JumpR) && bus.call;
        pop  = bus.JumpR && bus.ret;
        if (push && pop) begin
          if (m_ras.size() > 0) m_ras[m_ras.size()-1] = link;
        end else if (push) begin
          if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(link);
        end else if (pop) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
        end
      end
`endif
      m_pc = tgt; m_red = 1'b1; m_mis = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_top();
    return (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_pc"},    bus.pc,                   m_pc);
    check({tag, "_red"},   {31'b0, bus.redirect},    {31'b0, m_red});
    check({tag, "_mis"},   {31'b0, bus.misalign_err}, {31'b0, m_mis});
    check({tag, "_maddr"}, bus.misalign_addr,        m_maddr);
    check({tag, "_rasv"},  {31'b0, bus.ras_valid},   {31'b0, (m_ras.size() > 0)});
    check({tag, "_rast"},  bus.ras_top,              model_top());
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.flush_target = '0;
    bus.branch_taken = 0; bus.branch_target = '0;
    bus.Jump = 0; bus.jal_target = '0; bus.JumpR = 0; bus.jalr_target = '0;
    bus.call = 0; bus.ret = 0;
  endtask

  // One clock: advance the model with the applied inputs, then compare
  // 1 time unit after the rising edge.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset applied between edges, checked before any edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  localparam logic [31:0] RET_ADDR [4] = '{32'h44, 32'h34, 32'h24, 32'h14};

  logic [31:0] held;
  logic [31:0] exp_top;

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all("por");
    rst_n = 1'b1;

    // sequential fetch
    check("seq_pc0", bus.pc, 32'h0);
    for (int i = 0; i < 3; i++) tick("seq");
    check("seq_pcC", bus.pc, 32'hC);
    tick("seq");

    // JumpR beats Jump, flush beats both
    bus.Jump = 1; bus.jal_target = 32'h40; bus.JumpR = 1; bus.jalr_target = 32'h80;
    tick("prio");
    check("prio_pc", bus.pc, 32'h80);
    bus.flush = 1; bus.flush_target = 32'h200;
    tick("flush");
    check("flush_pc", bus.pc, 32'h200);
    idle();
    tick("postflush");
    check("postflush_red", {31'b0, bus.redirect}, 32'h0);

    // misaligned branch traps
    bus.branch_taken = 1; bus.branch_target = 32'h42;
    tick("mis");
    check("mis_pc", bus.pc, 32'h100);
    check("mis_addr", bus.misalign_addr, 32'h42);
    idle();
    tick("mis_end");
    check("mis_hold", bus.misalign_addr, 32'h42);

    // stall freezes PC, flush overrides stall
    held = bus.pc;
    bus.stall = 1; bus.Jump = 1; bus.jal_target = 32'h40;
    for (int i = 0; i < 3; i++) tick("stall");
    check("stall_pc", bus.pc, held);
    bus.flush = 1; bus.flush_target = 32'h300;
    tick("stallflush");
    check("stallflush_pc", bus.pc, 32'h300);
    idle();

    // silent wrap of pc+4
    bus.flush = 1; bus.flush_target = 32'hFFFF_FFFC;
    tick("wrap0");
    idle();
    tick("wrap1");
    check("wrap_pc", bus.pc, 32'h0);

    // reset during stall+flush, then first advance
    bus.stall = 1; bus.flush = 1; bus.flush_target = 32'h500;
    do_reset("rstmid");
    idle();
    tick("rstadv");
    check("rstadv_pc", bus.pc, RV + 32'd4);

    // return-address stack: 5 calls then 5 returns
    do_reset("ras_rst");
    for (int k = 0; k < 5; k++) begin
      bus.Jump = 1; bus.call = 1;
      bus.jal_target = (k < 4) ? 32'((k + 1) * 16) : 32'h1000;
      tick("call");
    end
    idle();
`ifdef PC_GEN_RAS_EN
    exp_top = 32'h44;
`else
    exp_top = 32'h0;
`endif
    check("call_top", bus.ras_top, exp_top);
    for (int k = 0; k < 4; k++) begin
`ifdef PC_GEN_RAS_EN
      exp_top = RET_ADDR[k];
`else
      exp_top = 32'h0;
`endif
      check("ret_top", bus.ras_top, exp_top);
      bus.JumpR = 1; bus.ret = 1; bus.jalr_target = RET_ADDR[k];
      tick("ret");
    end
    check("ret_empty", {31'b0, bus.ras_valid}, 32'h0);
    bus.JumpR = 1; bus.ret = 1; bus.jalr_target = 32'h800;
    tick("ret5");
    check("ret5_empty", {31'b0, bus.ras_valid}, 32'h0);
    idle();

    // randomized run against the model
    do_reset("rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      bus.stall         = ($urandom_range(0, 99) < 15);
      bus.flush         = ($urandom_range(0, 99) < 5);
      bus.flush_target  = $urandom;
      bus.branch_taken  = ($urandom_range(0, 99) < 30);
      bus.branch_target = rnd_tgt();
      bus.Jump          = ($urandom_range(0, 99) < 25);
      bus.jal_target    = rnd_tgt();
      bus.JumpR         = ($urandom_range(0, 99) < 25);
      bus.call          = ($urandom_range(0, 99) < 50);
      bus.ret           = ($urandom_range(0, 99) < 40);
      if (bus.ret && m_ras.size() > 0 && $urandom_range(0, 1) == 1)
        bus.jalr_target = model_top();
      else
        bus.jalr_target = rnd_tgt();
      tick("rnd");
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the bench can never run forever.
  initial begin
    #500000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0100, PC loaded on a misaligned control transfer.
REQ-004 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; power of two, minimum 2.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 stall  in  1  hold the PC.
REQ-008 flush  in  1  redirect to flush_target; overrides stall.
REQ-009 flush_target  in  XLEN  redirect address for flush.
REQ-010 branch_taken / branch_target  in  1 / XLEN  conditional branch request and its target.
REQ-011 Jump / jal_target  in  1 / XLEN  JAL request and its target.
REQ-012 JumpR / jalr_target  in  1 / XLEN  JALR request and its target.
REQ-013 call / ret  in  1 / 1  qualify Jump or JumpR as a call (link write) or a return.
REQ-014 pc  out  XLEN  current fetch PC (registered).
REQ-015 redirect  out  1  registered; high for one cycle after any non-sequential PC update.
REQ-016 misalign_err / misalign_addr  out  1 / XLEN  registered one-cycle pulse and the offending target.
REQ-017 ras_top / ras_valid  out  XLEN / 1  predicted return address and its validity.

Function
REQ-018 Advance condition: adv = ~stall & ~flush; with stall=1 and flush=0, pc, redirect=0 and RAS hold.
REQ-019 Next-PC priority on each edge: flush > JumpR > Jump > branch_taken > pc+4 (sequential).
REQ-020 pc+4 computed modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is silent.
REQ-021 flush loads flush_target unchecked for alignment; redirect=1 next cycle.
REQ-022 Selected JumpR/Jump/branch target with bits[1:0] != 0: pc <= TRAP_VECTOR, misalign_err=1 and misalign_addr=target for exactly one cycle, redirect=1, no RAS update.
REQ-023 Aligned taken JumpR/Jump/branch: pc <= target, redirect=1 next cycle; otherwise redirect=0.
REQ-024 misalign_addr holds its last value when misalign_err=0.
REQ-025 Push = adv & (Jump|JumpR) & call & aligned target; pushes pc+4.
REQ-026 Pop = adv & JumpR & ret & aligned target.
REQ-027 Push and pop in the same cycle: top entry replaced with pc+4, count unchanged.
REQ-028 Push when full: circular overwrite of the oldest entry, count saturates at RAS_DEPTH.
REQ-029 Pop when empty: no state change, ras_valid stays 0.
REQ-030 ras_valid = (count != 0); ras_top = top entry, 0 when empty.
REQ-031 flush does not modify the RAS.

Reset
REQ-032 rst_n low asynchronously forces pc=RESET_VECTOR, redirect=0, misalign_err=0, misalign_addr=0, RAS count=0, pointer=0, ras_valid=0, ras_top=0.
REQ-033 Reset asserted mid-stall or mid-flush overrides both; first post-reset edge with adv=1 yields RESET_VECTOR+4.

Configuration
REQ-034 Macro PC_GEN_RAS_EN defined: RAS per REQ-025..031 is built.
REQ-035 PC_GEN_RAS_EN undefined: no RAS storage; ras_top=0 and ras_valid=0 constant; call/ret ignored; all other behaviour identical.

Verification
REQ-036 Reset release, no requests, 3 edges -> pc 0x0, 0x4, 0x8, 0xC; redirect=0 throughout.
REQ-037 pc=0x10, Jump=1 jal_target=0x40, JumpR=1 jalr_target=0x80 same cycle -> pc=0x80, redirect=1 one cycle; flush=1 flush_target=0x200 added -> pc=0x200.
REQ-038 branch_taken=1 branch_target=0x42 -> pc=TRAP_VECTOR 0x100, misalign_err=1 for one cycle, misalign_addr=0x42.
REQ-039 stall=1 for 3 cycles with Jump=1 -> pc frozen; flush=1 during stall -> pc=flush_target next edge.
REQ-040 PC_GEN_RAS_EN, RAS_DEPTH=4: 5 calls from pc 0x0,0x10,0x20,0x30,0x40 -> ras_top=0x44; 4 returns yield 0x44,0x34,0x24,0x14, then ras_valid=0; a 5th return leaves ras_valid=0.
REQ-041 Without PC_GEN_RAS_EN: same call sequence -> ras_valid=0, ras_top=0 every cycle.
